mux_lut_eval: RTL

MUX_LUT_EVAL -- requirements
Module: mux_lut_eval

---
 rtl/mux_lut_pkg.sv | 13 +
 rtl/mux_lut_eval_if.sv | 25 ++
 rtl/mux_nx1.sv | 10 +
 rtl/mux_lut_eval.sv | 113 +++++++++++
 4 files changed

// File: rtl/mux_lut_pkg.sv
// mux_lut_pkg: leg-code constants and FSM state type shared by the mux LUT evaluator.
package mux_lut_pkg;
    localparam logic [1:0] CODE_ZERO = 2'b00;
    localparam logic [1:0] CODE_ONE  = 2'b01;
    localparam logic [1:0] CODE_VAR  = 2'b10;
    localparam logic [1:0] CODE_NVAR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SWEEP = 2'd2
    } state_e;
endpackage

// File: rtl/mux_lut_eval_if.sv
// mux_lut_eval_if: config, evaluation and sweep signals of the mux LUT evaluator.
interface mux_lut_eval_if #(parameter int NVAR = 3);
    logic            cfg_valid;
    logic [1:0]      cfg_code;
    logic            cfg_ready;
    logic            cfg_done;
    logic [NVAR-1:0] vars_in;
    logic            eval_valid;
    logic            sweep_start;
    logic            f_out;
    logic            f_valid;
    logic [NVAR-1:0] f_idx;
    logic            sweep_busy;
    logic            sweep_done;
    logic [NVAR:0]   ones_count;

    modport master (
        output cfg_valid, cfg_code, vars_in, eval_valid, sweep_start,
        input  cfg_ready, cfg_done, f_out, f_valid, f_idx, sweep_busy, sweep_done, ones_count
    );
    modport slave (
        input  cfg_valid, cfg_code, vars_in, eval_valid, sweep_start,
        output cfg_ready, cfg_done, f_out, f_valid, f_idx, sweep_busy, sweep_done, ones_count
    );
endinterface

// File: rtl/mux_nx1.sv
// mux_nx1: parametrised LEGS:1 single-bit multiplexer.
module mux_nx1 #(
    parameter int LEGS = 4
) (
    input  logic [LEGS-1:0]         i_data,
    input  logic [$clog2(LEGS)-1:0] i_sel,
    output logic                    o_y
);
    assign o_y = i_data[i_sel];
endmodule

// File: rtl/mux_lut_eval.sv
// mux_lut_eval: Boolean function of NVAR variables as a mux of leg codes over vars[0],
// with shadow/active table loading, single evaluation and exhaustive sweep.
module mux_lut_eval
    import mux_lut_pkg::*;
#(
    parameter int NVAR = 3
) (
    input logic           clk,
    input logic           rst,
    mux_lut_eval_if.slave bus
);
    localparam int LEGS = 2 ** (NVAR - 1);
    localparam int SW   = NVAR - 1;

    state_e                 r_state;
    logic [SW-1:0]          r_leg;
    logic [LEGS-1:0][1:0]   r_shadow, r_active;
    logic                   r_tvalid, r_cfg_done;
    logic                   r_f_out, r_f_valid, r_last, r_sweep_done;
    logic [NVAR-1:0]        r_f_idx, r_k;
    logic [NVAR:0]          r_acc, r_ones;

    logic                   w_xfer, w_commit, w_start, w_eval, w_sweeping, w_f;
    logic [NVAR-1:0]        w_x;
    logic [LEGS-1:0]        w_legs;
    logic [LEGS-1:0][1:0]   w_shadow_nxt;
    state_e                 w_state_nxt;

    assign w_sweeping = r_state == ST_SWEEP;
    assign w_xfer     = bus.cfg_valid && !w_sweeping;
    assign w_commit   = w_xfer && (&r_leg);
    assign w_start    = bus.sweep_start && r_tvalid && !w_sweeping;
    assign w_eval     = bus.eval_valid && r_tvalid && !w_sweeping;
    assign w_x        = w_sweeping ? r_k : bus.vars_in;

    always_comb begin
        w_shadow_nxt        = r_shadow;
        w_shadow_nxt[r_leg] = bus.cfg_code;
    end

    // Sweep wins over commit so a same-edge commit is swept from the new active table.
    assign w_state_nxt = w_sweeping ? ((&r_k) ? ST_IDLE : ST_SWEEP) :
                         w_start    ? ST_SWEEP :
                         w_commit   ? ST_IDLE  :
                         w_xfer     ? ST_LOAD  : r_state;

    for (genvar l = 0; l < LEGS; l++) begin : g_leg
        assign w_legs[l] = r_active[l] == CODE_ONE  ? 1'b1 :
                           r_active[l] == CODE_VAR  ? w_x[0] :
                           r_active[l] == CODE_NVAR ? ~w_x[0] : 1'b0;
    end

    mux_nx1 #(.LEGS(LEGS)) u_mux (
        .i_data (w_legs),
        .i_sel  (w_x[NVAR-1:1]),
        .o_y    (w_f)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_leg        <= '0;
            r_shadow     <= {LEGS{CODE_ZERO}};
            r_active     <= {LEGS{CODE_ZERO}};
            r_tvalid     <= 1'b0;
            r_cfg_done   <= 1'b0;
            r_f_out      <= 1'b0;
            r_f_valid    <= 1'b0;
            r_f_idx      <= '0;
            r_last       <= 1'b0;
            r_sweep_done <= 1'b0;
            r_k          <= '0;
            r_acc        <= '0;
            r_ones       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cfg_done   <= w_commit;
            if (w_xfer) begin
                r_shadow <= w_shadow_nxt;
                r_leg    <= r_leg + SW'(1);
            end
            if (w_commit) begin
                r_active <= w_shadow_nxt;
                r_tvalid <= 1'b1;
            end
            r_f_valid    <= w_eval || w_sweeping;
            if (w_eval || w_sweeping) begin
                r_f_out <= w_f;
                r_f_idx <= w_x;
            end
            r_last       <= w_sweeping && (&r_k);
            r_sweep_done <= r_last;
            if (w_start) begin
                r_k   <= '0;
                r_acc <= '0;
            end else if (w_sweeping) begin
                r_k   <= r_k + NVAR'(1);
                r_acc <= r_acc + (NVAR+1)'(w_f);
            end
            if (w_sweeping && (&r_k))
                r_ones <= r_acc + (NVAR+1)'(w_f);
        end
    end

    assign bus.cfg_ready  = !w_sweeping;
    assign bus.cfg_done   = r_cfg_done;
    assign bus.f_out      = r_f_out;
    assign bus.f_valid    = r_f_valid;
    assign bus.f_idx      = r_f_idx;
    assign bus.sweep_busy = w_sweeping;
    assign bus.sweep_done = r_sweep_done;
    assign bus.ones_count = r_ones;
endmodule
